cozy_constant_builder: RTL and testbench

Registered, handshaked constant unit for the cozy core. Decodes one 16-bit constant-load instruction per transfer and produces a WIDTH-bit immediate plus its destination register index. Generalises the four fixed 16-bit byte-placement modes to any WIDTH and adds multi-instruction prefix accumulation for wide constants. Sits between instruction decode and register-file writeback.

---
 rtl/cozy_constant_builder.sv | 150 +++++++++++++++
 tb/tb_cozy_constant_builder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cozy_constant_builder.sv
// ============================================================================
// Module      : cozy_constant_builder
// Description : Registered, handshaked constant unit. Decodes one 16-bit
//               constant-load instruction per transfer into a WIDTH-bit
//               immediate, with PREFIX/TAIL accumulation for wide constants.
//               Optional: COZY_CONST_SEXT_EN enables mode 6 (sign-extend B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cozy_constant_builder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             insn_valid,
    output logic             insn_ready,
    input  logic [15:0]      insn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       out_dest,
    output logic             err
);

    localparam int c_ACC_W = WIDTH - 8;
    localparam int c_CNT_W = $clog2(WIDTH / 8);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(WIDTH / 8 - 1);

    localparam logic [3:0] c_MODE_ZEXT   = 4'd0;
    localparam logic [3:0] c_MODE_ONES   = 4'd1;
    localparam logic [3:0] c_MODE_HI_00  = 4'd2;
    localparam logic [3:0] c_MODE_HI_FF  = 4'd3;
    localparam logic [3:0] c_MODE_PREFIX = 4'd4;
    localparam logic [3:0] c_MODE_TAIL   = 4'd5;
    localparam logic [3:0] c_MODE_SEXT   = 4'd6;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out;
    logic [3:0]         r_out_dest;
    logic               r_err;

    logic               w_accept;
    logic [3:0]         w_mode;
    logic [7:0]         w_b;
    logic               w_produce;
    logic               w_err;
    logic [WIDTH-1:0]   w_val;
    logic [c_ACC_W-1:0] w_acc_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_ovf_nxt;

    assign insn_ready = !r_out_valid || out_ready;
    assign w_accept   = insn_valid && insn_ready;
    assign w_mode     = insn[15:12];
    assign w_b        = insn[7:0];

    always_comb begin
        w_produce = 1'b0;
        w_err     = 1'b0;
        w_val     = '0;
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        case (w_mode)
            c_MODE_ZEXT, c_MODE_ONES, c_MODE_HI_00, c_MODE_HI_FF: begin
                w_produce = 1'b1;
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                w_ovf_nxt = 1'b0;
                case (w_mode)
                    c_MODE_ZEXT:  w_val = WIDTH'(w_b);
                    c_MODE_ONES:  w_val = {{(WIDTH-8){1'b1}}, w_b};
                    c_MODE_HI_00: w_val = WIDTH'({w_b, 8'h00});
                    default:      w_val = WIDTH'({w_b, 8'hFF});
                endcase
            end
            c_MODE_PREFIX: begin
                // A full accumulator keeps only the newest bytes and remembers the loss.
                w_acc_nxt = (r_acc << 8) | c_ACC_W'(w_b);
                if (r_cnt == c_CNT_MAX) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_MODE_TAIL: begin
                w_produce = 1'b1;
                w_val     = {r_acc, w_b};
                w_err     = r_ovf;
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                w_ovf_nxt = 1'b0;
            end
`ifdef COZY_CONST_SEXT_EN
            c_MODE_SEXT: begin
                w_produce = 1'b1;
                w_val     = {{(WIDTH-8){w_b[7]}}, w_b};
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                w_ovf_nxt = 1'b0;
            end
`endif
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_dest  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && w_err;
            if (w_accept) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_ovf <= w_ovf_nxt;
            end
            if (w_accept && w_produce) begin
                r_out_valid <= 1'b1;
                r_out       <= w_val;
                r_out_dest  <= insn[11:8];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_dest  = r_out_dest;
    assign err       = r_err;

    // Unused mode value keeps lint quiet when mode 6 is compiled out.
    logic w_unused;
    assign w_unused = (c_MODE_SEXT == 4'd6);

endmodule

`default_nettype wire

// File: tb/tb_cozy_constant_builder.sv
// ============================================================================
// Module      : tb_cozy_constant_builder
// Description : Directed self-checking bench; WIDTH=16 and WIDTH=32 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cozy_constant_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_ivalid = 1'b0, a_iready, a_ovalid, a_ordy = 1'b1, a_err;
    logic [15:0] a_insn = '0, a_out;
    logic [3:0]  a_dest;

    logic        b_ivalid = 1'b0, b_iready, b_ovalid, b_ordy = 1'b1, b_err;
    logic [15:0] b_insn = '0;
    logic [31:0] b_out;
    logic [3:0]  b_dest;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cozy_constant_builder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .insn_valid(a_ivalid), .insn_ready(a_iready), .insn(a_insn),
        .out_valid(a_ovalid), .out_ready(a_ordy), .out(a_out),
        .out_dest(a_dest), .err(a_err)
    );

    cozy_constant_builder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .insn_valid(b_ivalid), .insn_ready(b_iready), .insn(b_insn),
        .out_valid(b_ovalid), .out_ready(b_ordy), .out(b_out),
        .out_dest(b_dest), .err(b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue_a(input logic [15:0] i);
        a_ivalid = 1'b1;
        a_insn   = i;
        @(posedge clk);
        #1;
        a_ivalid = 1'b0;
    endtask

    task automatic issue_b(input logic [15:0] i);
        b_ivalid = 1'b1;
        b_insn   = i;
        @(posedge clk);
        #1;
        b_ivalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vin  [4];
        logic [15:0] vexp [4];
        vin  = '{16'h0112, 16'h1112, 16'h2112, 16'h3112};
        vexp = '{16'h0012, 16'hFF12, 16'h1200, 16'h12FF};

        // Reset state
        @(posedge clk); #1;
        check("rst_a_valid", a_ovalid, 0);
        check("rst_a_out",   a_out,    0);
        check("rst_a_dest",  a_dest,   0);
        check("rst_a_err",   a_err,    0);
        check("rst_b_valid", b_ovalid, 0);
        check("rst_b_out",   b_out,    0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back byte-placement modes
        a_ordy   = 1'b1;
        a_ivalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_insn = vin[k];
            @(posedge clk); #1;
            check("b2b_out",   a_out,    vexp[k]);
            check("b2b_dest",  a_dest,   4'd1);
            check("b2b_valid", a_ovalid, 1);
            check("b2b_err",   a_err,    0);
        end
        a_ivalid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drop", a_ovalid, 0);

        // WIDTH=32 prefix accumulation
        issue_b(16'h4012);
        check("w32_p_valid", b_ovalid, 0);
        issue_b(16'h4034);
        issue_b(16'h4056);
        check("w32_p_err", b_err, 0);
        issue_b(16'h5778);
        check("w32_out",  b_out,    32'h12345678);
        check("w32_dest", b_dest,   4'd7);
        check("w32_valid", b_ovalid, 1);
        check("w32_err",  b_err,    0);

        // WIDTH=16 prefix overflow
        issue_a(16'h40AA);
        check("ovf_p1_err", a_err, 0);
        issue_a(16'h40BB);
        check("ovf_p2_err", a_err, 0);
        check("ovf_p_valid", a_ovalid, 0);
        issue_a(16'h50CC);
        check("ovf_out",   a_out,    16'hBBCC);
        check("ovf_valid", a_ovalid, 1);
        check("ovf_err",   a_err,    1);
        @(posedge clk); #1;
        check("ovf_err_pulse", a_err, 0);
        issue_a(16'h5000);
        check("tail0_out", a_out, 16'h0000);
        check("tail0_err", a_err, 0);
        @(posedge clk); #1;

        // Illegal mode
        issue_a(16'hF3AB);
        check("ill_valid", a_ovalid, 0);
        check("ill_err",   a_err,    1);

        // Backpressure
        a_ordy = 1'b0;
        issue_a(16'h0155);
        check("bp_out0", a_out, 16'h0055);
        a_ivalid = 1'b1;
        a_insn   = 16'h0266;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", a_iready, 0);
            check("bp_hold",  a_out,    16'h0055);
            check("bp_valid", a_ovalid, 1);
            @(posedge clk); #1;
        end
        a_ordy = 1'b1;
        #1;
        check("bp_ready_up", a_iready, 1);
        @(posedge clk); #1;
        a_ivalid = 1'b0;
        check("bp_out1",   a_out,    16'h0066);
        check("bp_valid1", a_ovalid, 1);
        check("bp_dest1",  a_dest,   4'd2);
        @(posedge clk); #1;

        // Mode 6 on WIDTH=32
        issue_b(16'h6080);
`ifdef COZY_CONST_SEXT_EN
        check("sext_valid", b_ovalid, 1);
        check("sext_out",   b_out,    32'hFFFFFF80);
        check("sext_err",   b_err,    0);
`else
        check("m6_valid", b_ovalid, 0);
        check("m6_err",   b_err,    1);
`endif
        @(posedge clk); #1;

        // Reset mid-sequence
        issue_b(16'h4012);
        a_ordy = 1'b0;
        issue_a(16'h0177);
        check("pre_rst_valid", a_ovalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_a_valid", a_ovalid, 0);
        check("arst_a_out",   a_out,    0);
        check("arst_a_dest",  a_dest,   0);
        #2;
        rst    = 1'b0;
        a_ordy = 1'b1;
        @(posedge clk); #1;
        issue_b(16'h5034);
        check("post_rst_out",  b_out,    32'h00000034);
        check("post_rst_dest", b_dest,   4'd0);
        check("post_rst_err",  b_err,    0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
